seven_seg_scan_driver: RTL and testbench

Consumer end of the 28-bit segment bus produced by the BCD counter and 7-segment mapping stage. Time-multiplexes four 7-segment digit patterns onto one shared segment bus and four anode lines, with configurable refresh rate and inter-digit blanking. Patterns are captured once per frame so the display never tears. Sits between the counter/mapping logic and the board's 4-digit display pins.

---
 rtl/seven_seg_scan_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_driver
// Description : Time-multiplexed scan driver for a 4-digit 7-segment display.
//               Takes four 7-bit segment patterns and drives them one digit
//               at a time onto a shared segment bus and four anode lines.
//               Each digit slot begins with a blanking interval, which stops
//               one digit's pattern from ghosting onto the next.
//               The patterns and enables are captured once per frame, so a
//               frame never mixes old and new data.
//
// Ports       : clk_in          - system clock
//               reset_n_in      - asynchronous active-low reset
//               segments_in     - [6:0] digit0 .. [27:21] digit3, 1 = lit
//               digit_enable_in - per-digit enable, 0 keeps the digit dark
//               seg_out         - shared segment drive (SEG_ACTIVE_LOW)
//               anode_out       - one-hot digit select (AN_ACTIVE_LOW)
//               frame_done_out  - pulse during the frame capture cycle
//
// Parameters  : REFRESH_DIV    - clock cycles per digit slot (>= 2)
//               BLANK_CYCLES   - off cycles at the start of each slot,
//                                LOAD included (1 .. REFRESH_DIV-1)
//               SEG_ACTIVE_LOW - 1: a lit segment is driven 0
//               AN_ACTIVE_LOW  - 1: the selected anode is driven 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [27:0] segments_in,
    input  logic [3:0]  digit_enable_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  anode_out,
    output logic        frame_done_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    // Inactive levels of the pins. XOR with these values converts the
    // internal "1 = on" representation to the polarity of the pins.
    localparam logic [6:0] C_SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0] C_AN_OFF  = {4{AN_ACTIVE_LOW}};

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_idx;
    logic [1:0]         w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;

    logic [27:0]        r_shadow_seg;
    logic [27:0]        w_shadow_seg_nxt;
    logic [3:0]         r_shadow_en;
    logic [3:0]         w_shadow_en_nxt;
    logic               w_capture;

    logic [6:0]         r_seg;
    logic [3:0]         r_anode;
    logic [6:0]         w_lit_nxt;
    logic [3:0]         w_sel_nxt;
    logic [6:0]         w_seg_nxt;
    logic [3:0]         w_anode_nxt;

    // ------------------------------------------------------------------------
    // FSM state register, digit index and slot counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= ST_LOAD;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // Each slot lasts REFRESH_DIV cycles: one LOAD cycle, then BLANK up to
    // cnt == BLANK_CYCLES-1, then DRIVE up to cnt == REFRESH_DIV-1.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;

        case (r_state)
            ST_LOAD: begin
                w_cnt_nxt   = r_cnt + 1'b1;
                // The capture happens only at the start of the frame. This
                // keeps all four slots of one frame on the same data.
                w_capture   = (r_idx == 2'd0);
                // With a single blanking cycle, LOAD itself is the blanking.
                w_state_nxt = (BLANK_CYCLES > 1) ? ST_BLANK : ST_DRIVE;
            end

            ST_BLANK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == C_BLANK_LAST) begin
                    w_state_nxt = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + 2'd1;
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_cnt_nxt   = '0;
                w_idx_nxt   = 2'd0;
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Frame shadow registers
    // ------------------------------------------------------------------------
    always_comb begin
        w_shadow_seg_nxt = r_shadow_seg;
        w_shadow_en_nxt  = r_shadow_en;
        if (w_capture) begin
            w_shadow_seg_nxt = segments_in;
            w_shadow_en_nxt  = digit_enable_in;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode
    // The decode uses the next state, so the output flops always hold the
    // decode of the state that is current in the same cycle. The pins stay
    // glitch-free and have no combinational path from the data inputs.
    // ------------------------------------------------------------------------
    always_comb begin
        w_lit_nxt = 7'h00;
        w_sel_nxt = 4'h0;

        if ((w_state_nxt == ST_DRIVE) && w_shadow_en_nxt[w_idx_nxt]) begin
            case (w_idx_nxt)
                2'd0: begin
                    w_lit_nxt = w_shadow_seg_nxt[6:0];
                    w_sel_nxt = 4'b0001;
                end
                2'd1: begin
                    w_lit_nxt = w_shadow_seg_nxt[13:7];
                    w_sel_nxt = 4'b0010;
                end
                2'd2: begin
                    w_lit_nxt = w_shadow_seg_nxt[20:14];
                    w_sel_nxt = 4'b0100;
                end
                default: begin
                    w_lit_nxt = w_shadow_seg_nxt[27:21];
                    w_sel_nxt = 4'b1000;
                end
            endcase
        end

        w_seg_nxt   = w_lit_nxt ^ C_SEG_OFF;
        w_anode_nxt = w_sel_nxt ^ C_AN_OFF;
    end

    // ------------------------------------------------------------------------
    // Shadow and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_shadow_seg <= 28'h0;
            r_shadow_en  <= 4'h0;
            r_seg        <= C_SEG_OFF;
            r_anode      <= C_AN_OFF;
        end else begin
            r_shadow_seg <= w_shadow_seg_nxt;
            r_shadow_en  <= w_shadow_en_nxt;
            r_seg        <= w_seg_nxt;
            r_anode      <= w_anode_nxt;
        end
    end

    assign seg_out   = r_seg;
    assign anode_out = r_anode;

    // Reset leaves the FSM at the digit-0 LOAD cycle. Gating with the reset
    // input keeps the pulse low while reset is held. The pulse then marks the
    // first cycle after release, which is the fresh capture cycle.
    assign frame_done_out = reset_n_in && (r_state == ST_LOAD) && (r_idx == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_driver
// Description : Directed testbench for seven_seg_scan_driver. It runs three
//               instances side by side:
//                 dut_a : REFRESH_DIV=8, BLANK_CYCLES=2, both active-low
//                 dut_b : REFRESH_DIV=8, BLANK_CYCLES=2, both active-high
//                 dut_c : REFRESH_DIV=2, BLANK_CYCLES=1, both active-low
//               All three share clock, reset and data inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    localparam logic [27:0] SEG_BASE = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    localparam logic [27:0] SEG_CHG  = {7'h4F, 7'h5B, 7'h06, 7'h7F};

    logic        clk;
    logic        rst_n;
    logic [27:0] segs;
    logic [3:0]  en;

    logic [6:0]  seg_a, seg_b, seg_c;
    logic [3:0]  an_a, an_b, an_c;
    logic        fd_a, fd_b, fd_c;

    int total;
    int bad;
    int cyc;
    int phase;

    logic [6:0] pat [4];

    seven_seg_scan_driver #(
        .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk_in(clk), .reset_n_in(rst_n), .segments_in(segs), .digit_enable_in(en),
        .seg_out(seg_a), .anode_out(an_a), .frame_done_out(fd_a)
    );

    seven_seg_scan_driver #(
        .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk_in(clk), .reset_n_in(rst_n), .segments_in(segs), .digit_enable_in(en),
        .seg_out(seg_b), .anode_out(an_b), .frame_done_out(fd_b)
    );

    seven_seg_scan_driver #(
        .REFRESH_DIV(2), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
    ) dut_c (
        .clk_in(clk), .reset_n_in(rst_n), .segments_in(segs), .digit_enable_in(en),
        .seg_out(seg_c), .anode_out(an_c), .frame_done_out(fd_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s phase=%0d cyc=%0d observed=%h expected=%h", tag, phase, cyc, obs, exp_v);
        end
    endtask

    // At most one anode active; segments off when no anode is active.
    task automatic chk_inv(input string tag, input logic [3:0] an, input logic [6:0] seg,
                           input bit low);
        logic [3:0] act;
        logic [6:0] seg_off;
        logic       ok1;
        act     = low ? ~an : an;
        seg_off = low ? 7'h7F : 7'h00;
        ok1     = $onehot0(act);
        chk({tag, "_onehot"}, {31'b0, ok1}, 32'd1);
        if (act == 4'h0) chk({tag, "_segoff"}, {25'b0, seg}, {25'b0, seg_off});
    endtask

    // Expected outputs for cycle cyc. Inputs are the slot length, the
    // number of blank cycles, the enables captured for the frame, whether
    // digit 0 holds the changed pattern, and the output polarity.
    task automatic check_dut(input string tag, input int div, input int blank,
                             input logic [3:0] en_cap, input bit d0new, input bit low,
                             input logic [6:0] seg, input logic [3:0] an, input logic fd);
        int         slot;
        int         pos;
        logic       drive;
        logic [6:0] lit;
        logic [3:0] sel;
        logic [6:0] exp_seg;
        logic [3:0] exp_an;
        logic       exp_fd;
        slot  = (cyc / div) % 4;
        pos   = cyc % div;
        drive = (pos >= blank) && en_cap[slot];
        lit   = (slot == 0 && d0new) ? 7'h7F : pat[slot];
        sel   = 4'b0001 << slot;
        if (!drive) begin
            lit = 7'h00;
            sel = 4'h0;
        end
        exp_seg = low ? ~lit : lit;
        exp_an  = low ? ~sel : sel;
        exp_fd  = ((cyc % (4 * div)) == 0);
        chk({tag, "_anode"}, {28'b0, an}, {28'b0, exp_an});
        chk({tag, "_seg"}, {25'b0, seg}, {25'b0, exp_seg});
        chk({tag, "_frame_done"}, {31'b0, fd}, {31'b0, exp_fd});
        chk_inv(tag, an, seg, low);
    endtask

    task automatic check_now();
        logic [3:0] en_ab;
        logic [3:0] en_c;
        bit         d0_ab;
        bit         d0_c;
        en_ab = 4'hF;
        en_c  = 4'hF;
        d0_ab = 1'b0;
        d0_c  = 1'b0;
        if (phase == 1) begin
            // digit0 changes in cycle 5: dut_a/b capture it at cycle 32, dut_c at 8
            d0_ab = (cyc >= 32);
            d0_c  = (cyc >= 8);
        end
        if (phase == 3) begin
            // 0101 only during cycle 0; dut_c recaptures 4'hF at cycle 8
            en_ab = 4'b0101;
            en_c  = (cyc < 8) ? 4'b0101 : 4'hF;
        end
        check_dut("a", 8, 2, en_ab, d0_ab, 1'b1, seg_a, an_a, fd_a);
        check_dut("b", 8, 2, en_ab, d0_ab, 1'b0, seg_b, an_b, fd_b);
        check_dut("c", 2, 1, en_c, d0_c, 1'b1, seg_c, an_c, fd_c);
    endtask

    task automatic run_to(input int last);
        while (cyc < last) begin
            @(posedge clk);
            #1;
            cyc++;
            if (phase == 1 && cyc == 5) segs = SEG_CHG;
            if (phase == 3 && cyc == 1) en = 4'hF;
            @(negedge clk);
            check_now();
        end
    endtask

    // Release just after a rising edge; the rest of that period is cycle 0.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        @(negedge clk);
        check_now();
    endtask

    task automatic chk_off(input string tag);
        chk({tag, "_a_anode"}, {28'b0, an_a}, 32'h0000_000F);
        chk({tag, "_a_seg"}, {25'b0, seg_a}, 32'h0000_007F);
        chk({tag, "_a_fd"}, {31'b0, fd_a}, 32'd0);
        chk({tag, "_b_anode"}, {28'b0, an_b}, 32'h0000_0000);
        chk({tag, "_b_seg"}, {25'b0, seg_b}, 32'h0000_0000);
        chk({tag, "_b_fd"}, {31'b0, fd_b}, 32'd0);
        chk({tag, "_c_anode"}, {28'b0, an_c}, 32'h0000_000F);
        chk({tag, "_c_seg"}, {25'b0, seg_c}, 32'h0000_007F);
        chk({tag, "_c_fd"}, {31'b0, fd_c}, 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        cyc    = 0;
        phase  = 0;
        pat[0] = 7'h3F;
        pat[1] = 7'h06;
        pat[2] = 7'h5B;
        pat[3] = 7'h4F;
        rst_n  = 1'b0;
        segs   = SEG_BASE;
        en     = 4'hF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_off("reset");

        // Phase 1: basic scan, tear-free capture, frame_done at 0/32/64
        phase = 1;
        release_reset();
        run_to(66);

        // Phase 2: asynchronous reset while digit 2 is driving
        phase = 2;
        rst_n = 1'b0;
        segs  = SEG_BASE;
        en    = 4'hF;
        repeat (2) @(posedge clk);
        release_reset();
        run_to(20);
        rst_n = 1'b0;
        #1;
        chk_off("async_reset");
        repeat (2) @(posedge clk);
        release_reset();
        run_to(31);

        // Phase 3: digit enable 0101 captured at frame start
        phase = 3;
        rst_n = 1'b0;
        segs  = SEG_BASE;
        en    = 4'b0101;
        repeat (2) @(posedge clk);
        release_reset();
        run_to(31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
